// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the IF-stage next-PC controller:
// PC width, default reset vector and the controller state encoding.
package pipe_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = '0;

   // BOOT  : one dead cycle after reset, pc parked at the reset vector
   // RUN   : sequential fetch
   // HOLD  : stalled by the hazard unit, nothing pending
   // PEND  : stalled with a redirect target waiting in pend_pc
   // FLUSH : bubble cycles after a redirect has been applied to pc
   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_RUN   = 3'd1,
      ST_HOLD  = 3'd2,
      ST_PEND  = 3'd3,
      ST_FLUSH = 3'd4
   } pc_sel_state_t;

   // States in which the instruction at pc is a real fetch.
   function automatic logic fetch_live(input pc_sel_state_t s);
      return (s == ST_RUN) || (s == ST_HOLD) || (s == ST_PEND);
   endfunction

endpackage

// File: rtl/pc_inc_adder.sv
// Sequential-PC adder: sum_o = a_i + INC, wrapping modulo 2^W.
module pc_inc_adder
   import pipe_pkg::*;
#(
   parameter int W   = PC_W,
   parameter int INC = 4
) (
   input  logic [W-1:0] a_i,
   output logic [W-1:0] sum_o
);

   // Plain modular add; no alignment check on the incoming PC.
   assign sum_o = a_i + W'(INC);

endmodule

// File: rtl/pc_sel_ctrl.sv
// Next-PC controller for the IF stage. Owns the PC register, drives the
// select and A-input of the external 2:1 PC mux, tracks stalls, parks
// redirects that arrive while stalled, and produces the registered
// flush / fetch_valid qualifiers for the IF/ID latch.
//
// Optional build macro PC_SEL_REDIRECT_CNT_EN adds a 16-bit wrapping count
// (redirect_cnt) of redirect targets actually loaded into pc.
//
// Handshake note: there is no valid/ready pair here. redirect is a one-cycle
// pulse qualified only by itself; redirect_pc is meaningful only while
// redirect=1. stall is a level that freezes pc for as long as it is high.
module pc_sel_ctrl
   import pipe_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
   parameter int              PC_INC       = 4,
   parameter int              FLUSH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] npc,
   output logic            mux_sel,
   output logic [PC_W-1:0] mux_target,
   output logic            fetch_valid,
   output logic            flush,
`ifdef PC_SEL_REDIRECT_CNT_EN
   output logic [15:0]     redirect_cnt,
`endif
   output pc_sel_state_t   state_dbg
);

   localparam logic [1:0] BUB_INIT = 2'(FLUSH_CYCLES);

   pc_sel_state_t   state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pend_q, pend_d;
   logic [1:0]      bub_q, bub_d;
   logic            fetch_valid_q;
   logic            flush_q;
   logic [PC_W-1:0] npc_w;

   pc_inc_adder #(
      .W   (PC_W),
      .INC (PC_INC)
   ) u_pc_inc_adder (
      .a_i   (pc_q),
      .sum_o (npc_w)
   );

   // Next-state, next-pc and mux controls. Redirect beats stall in RUN and
   // FLUSH; while parked (PEND) the youngest target wins and mux_sel stays
   // high because the next pc load will be that target.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      bub_d      = bub_q;
      mux_sel    = 1'b0;
      mux_target = redirect ? redirect_pc : '0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               bub_d   = BUB_INIT;
               mux_sel = 1'b1;
               state_d = ST_FLUSH;
            end else if (stall) begin
               state_d = ST_HOLD;
            end else begin
               pc_d = npc_w;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pend_d  = redirect_pc;
               state_d = ST_PEND;
            end else if (!stall) begin
               pc_d    = npc_w;
               state_d = ST_RUN;
            end
         end
         ST_PEND: begin
            mux_sel    = 1'b1;
            mux_target = redirect ? redirect_pc : pend_q;
            if (redirect) begin
               pend_d = redirect_pc;
            end
            if (!stall) begin
               pc_d    = mux_target;
               bub_d   = BUB_INIT;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               bub_d   = BUB_INIT;
               mux_sel = 1'b1;
            end else if (!stall) begin
               pc_d = npc_w;
               if (bub_q <= 2'd1) begin
                  bub_d   = 2'd0;
                  state_d = ST_RUN;
               end else begin
                  bub_d = bub_q - 2'd1;
               end
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State and PC registers; the qualifiers are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         pend_q        <= '0;
         bub_q         <= '0;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_q        <= pend_d;
         bub_q         <= bub_d;
         fetch_valid_q <= fetch_live(state_d);
         flush_q       <= (state_d == ST_FLUSH);
      end
   end

`ifdef PC_SEL_REDIRECT_CNT_EN
   logic [15:0] redirect_cnt_q;
   logic        applied;

   // A target is applied whenever mux_sel is high and pc is actually loaded;
   // in PEND that needs stall low, elsewhere mux_sel already implies a load.
   assign applied = mux_sel && !((state_q == ST_PEND) && stall);

   // Count redirects loaded into pc (overwrites while parked do not count).
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_cnt_q <= '0;
      end else if (applied) begin
         redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
   end

   assign redirect_cnt = redirect_cnt_q;
`endif

   assign pc          = pc_q;
   assign npc         = npc_w;
   assign fetch_valid = fetch_valid_q;
   assign flush       = flush_q;
   assign state_dbg   = state_q;

endmodule

// File: doc/pc_sel_ctrl.md
# pc_sel_ctrl

Next-PC controller for the IF stage. Owns the program counter register and drives the select line of the 32-bit 2:1 PC mux, choosing sequential PC+4 or a redirect target from EX/MEM. Handles pipeline stalls, latches redirects that arrive while stalled, and emits flush and fetch-valid qualifiers toward the IF/ID latch.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- PC_INC, 4, sequential increment added to PC
- FLUSH_CYCLES, 1, bubble cycles inserted after a redirect (1..3)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit holds IF; PC must not advance
- redirect  in  1  EX/MEM taken branch/jump, one-cycle pulse
- redirect_pc  in  32  target, valid when redirect=1
- pc  out  32  current fetch address (registered)
- npc  out  32  pc + PC_INC (combinational, mod 2^32)
- mux_sel  out  1  PC mux select: 1 = redirect target, 0 = npc
- mux_target  out  32  value presented to mux input A (live or latched target)
- fetch_valid  out  1  current pc is a real fetch; 0 = bubble
- flush  out  1  kill the instruction in IF/ID this cycle

## Operation
- States: BOOT, RUN, HOLD, PEND, FLUSH (encoding in package).
- BOOT: entered on rst; pc=RESET_PC, fetch_valid=0. Next cycle -> RUN unconditionally.
- RUN: fetch_valid=1. redirect=1 (with or without stall): pc<=redirect_pc, flush=1 next cycle, -> FLUSH. stall=1 with no redirect: -> HOLD. Otherwise pc<=npc.
- HOLD: pc and outputs frozen, fetch_valid=1. redirect=1 -> latch redirect_pc into pend_pc, -> PEND. stall=0 -> RUN and pc<=npc that edge.
- PEND: pc frozen, mux_sel=1, mux_target=pend_pc. A new redirect overwrites pend_pc (youngest wins). stall=0 -> pc<=pend_pc, -> FLUSH.
- FLUSH: flush=1, fetch_valid=0, pc<=npc each cycle not stalled, for FLUSH_CYCLES cycles then -> RUN. stall=1 freezes pc and the bubble counter. redirect in FLUSH restarts it: pc<=redirect_pc, counter reloaded.
- mux_sel=1 exactly when the next pc load takes a redirect target; else 0.
- Arithmetic: npc wraps 32'hFFFFFFFC + 4 -> 32'h00000000; no alignment check.

## Timing
- Reset values: pc=RESET_PC, npc=RESET_PC+PC_INC, mux_sel=0, mux_target=0, fetch_valid=0, flush=0, pend_pc=0, state=BOOT.
- rst overrides all inputs on the same edge; rst mid-PEND or mid-FLUSH discards pending target.
- Redirect latency: redirect at edge N -> pc=target after edge N+1 when not stalled.
- flush and fetch_valid are registered, change only on clk edges; npc and mux_sel/mux_target are combinational from state, pc, redirect, redirect_pc, pend_pc.
- Simultaneous stall and redirect in RUN: redirect takes priority over stall.

## Configuration
- PC_SEL_REDIRECT_CNT_EN defined: adds output redirect_cnt (16 bits), reset 0, increments once per redirect applied to pc (not per overwrite in PEND), wraps at 16'hFFFF->0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package pipe_pkg: state enum pc_sel_state_t, constant PC_W=32, default RESET_PC.
- One sub-module: pc_inc_adder (PC_W adder with parameterised increment); mux itself stays external.

## Test plan
- Reset: rst high 2 cycles, RESET_PC=32'h00000000 -> pc=0, fetch_valid=0 one cycle, then pc 0,4,8,C.
- Redirect in RUN: at pc=8 pulse redirect, target 32'h00000100 -> mux_sel=1 that cycle, pc=100, flush=1 one cycle, then 104.
- Redirect during stall: stall 3 cycles at pc=C, redirect 32'hA5A5A5A4 then 32'hDDDDDDDC in stall -> pc stays C, release -> pc=DDDDDDDC.
- Stall + redirect same cycle in RUN: target 32'h40 -> pc=40, stall ignored for that edge.
- Wrap: pc=FFFFFFFC, no stall -> next pc=00000000.
- With PC_SEL_REDIRECT_CNT_EN: three applied redirects, one overwritten in PEND -> redirect_cnt=3; rst -> 0.
